gear_var: RTL

//  Parametrised single-clock width gearbox: repacks a framed IN_W-bit word stream into an
//  OUT_W-bit word stream. MSB-first, no bits lost, with ready/valid backpressure on both sides.

---
 rtl/gear_var_pkg.sv | 22 ++
 rtl/gear_var_if.sv | 27 ++
 rtl/gear_var_acc.sv | 70 +++++++
 rtl/gear_var.sv | 87 ++++++++
 4 files changed

// File: rtl/gear_var_pkg.sv
// Shared types and helpers for the gear_var width gearbox.
package gear_var_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Returns a vector whose low nbits bits all equal the pad value.
  function automatic logic [127:0] pad_fill(input logic pad, input int nbits);
    logic [127:0] fill = '0;
    for (int i = 0; i < nbits; i++) fill[i] = pad;
    return fill;
  endfunction

endpackage

// File: rtl/gear_var_if.sv
// Stream-side signals of the gearbox: framed input words in, framed output words out.
interface gear_var_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  datin;
  logic             davin;
  logic             fstin;
  logic             lstin;
  logic             dinrdy;
  logic [OUT_W-1:0] datout;
  logic             davout;
  logic             fstout;
  logic             lstout;
  logic             doutrdy;
  logic             errfrm;

  modport master (
    output datin, davin, fstin, lstin, doutrdy,
    input  dinrdy, datout, davout, fstout, lstout, errfrm
  );

  modport slave (
    input  datin, davin, fstin, lstin, doutrdy,
    output dinrdy, datout, davout, fstout, lstout, errfrm
  );
endinterface

// File: rtl/gear_var_acc.sv
// Gearbox datapath: MSB-aligned bit accumulator with shift-out-by-OUT_W and insert-at-count.
module gear_var_acc
  import gear_var_pkg::*;
#(
  parameter int   IN_W  = 24,
  parameter int   OUT_W = 16,
  parameter logic PAD   = 1'b0,
  localparam int  ACC_W = IN_W + OUT_W,
  localparam int  CW    = clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             push,
  input  logic             pop,
  input  logic             discard,
  input  logic [IN_W-1:0]  datin,
  output logic [OUT_W-1:0] datout,
  output logic [CW-1:0]    cnt,
  output logic [CW-1:0]    cnt_pop,
  output logic [CW-1:0]    cnt_next
);

  localparam logic [127:0]     PAD_ALL = pad_fill(PAD, ACC_W);
  localparam logic [ACC_W-1:0] FILL    = PAD_ALL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] ONES    = '1;
  localparam logic [CW-1:0]    OUT_C   = CW'(OUT_W);
  localparam logic [CW-1:0]    IN_C    = CW'(IN_W);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_pop;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] word_ext;
  logic [ACC_W-1:0] keep_mask;
  logic [ACC_W-1:0] tail_mask;
  logic [CW-1:0]    base;

  assign datout = acc[ACC_W-1 -: OUT_W];

  // cnt_pop is reported before any frame-error discard so the caller can detect the error
  // without a combinational loop; base is the insertion offset actually used.
  always_comb begin
    acc_pop = acc;
    cnt_pop = cnt;
    if (pop) begin
      acc_pop = {acc[ACC_W-OUT_W-1:0], FILL[OUT_W-1:0]};
      cnt_pop = (cnt > OUT_C) ? cnt - OUT_C : '0;
    end
    base      = discard ? '0 : cnt_pop;
    word_ext  = {datin, {OUT_W{1'b0}}} >> base;
    keep_mask = ~(ONES >> base);
    tail_mask = ONES >> (base + IN_C);
    acc_next  = acc_pop;
    cnt_next  = cnt_pop;
    if (push) begin
      acc_next = (acc_pop & keep_mask) | word_ext | (FILL & tail_mask);
      cnt_next = base + IN_C;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/gear_var.sv
// Framed IN_W -> OUT_W width gearbox with ready/valid on both sides and tail flush.
module gear_var
  import gear_var_pkg::*;
#(
  parameter int   IN_W  = 24,
  parameter int   OUT_W = 16,
  parameter logic PAD   = 1'b0
) (
  input logic     clk,
  input logic     init_n,
  gear_var_if.slave bus
);

  localparam int            ACC_W = IN_W + OUT_W;
  localparam int            CW    = clog2(ACC_W + 1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_W);
  localparam logic [CW-1:0] ROOM  = CW'(ACC_W - IN_W);

  state_t        state;
  state_t        state_next;
  logic          fst_pend;
  logic          errfrm_q;
  logic          live;
  logic          push;
  logic          pop;
  logic          frame_err;
  logic          dinrdy;
  logic          davout;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_pop;
  logic [CW-1:0] cnt_next;

  // live holds dinrdy low during reset and for the release cycle, so all outputs read 0.
  assign dinrdy    = live & (state == RUN) & (cnt <= ROOM);
  assign davout    = (cnt >= OUT_C) | ((state == FLUSH) & (cnt != '0));
  assign push      = bus.davin & dinrdy;
  assign pop       = davout & bus.doutrdy;
  assign frame_err = push & bus.fstin & (cnt_pop != '0);

  assign bus.dinrdy = dinrdy;
  assign bus.davout = davout;
  assign bus.fstout = fst_pend & davout;
  assign bus.lstout = (state == FLUSH) & davout & (cnt <= OUT_C);
  assign bus.errfrm = errfrm_q;

  gear_var_acc #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .PAD  (PAD)
  ) u_acc (
    .clk     (clk),
    .init_n  (init_n),
    .push    (push),
    .pop     (pop),
    .discard (frame_err),
    .datin   (bus.datin),
    .datout  (bus.datout),
    .cnt     (cnt),
    .cnt_pop (cnt_pop),
    .cnt_next(cnt_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (push & bus.lstin) state_next = FLUSH;
      FLUSH:   if (pop & (cnt_next == '0)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= RUN;
      fst_pend <= 1'b0;
      errfrm_q <= 1'b0;
      live     <= 1'b0;
    end else begin
      state <= state_next;
      live  <= 1'b1;
      if (push & bus.fstin) fst_pend <= 1'b1;
      else if (pop)         fst_pend <= 1'b0;
      if (frame_err) errfrm_q <= 1'b1;
    end
  end

endmodule
